// File: rtl/seq_layer_pkg.sv
// Shared fixed-point definitions for the sequential layer and its helpers.
//   N, FRAC      : default word width and fractional bits (Q(N-FRAC).FRAC)
//   MAXV, MINV   : saturation bounds for the default N (64-bit signed)
//   act_mode_e   : activation encodings (3 is reserved and behaves as linear)
//   state_e      : sequencer states of seq_layer
//   sat_max/min  : saturation bounds for an arbitrary word width
//   saturate     : clamp a 64-bit signed value into [lo, hi]
package seq_layer_pkg;

  localparam int N    = 16;
  localparam int FRAC = 8;

  function automatic logic signed [63:0] sat_max(input int n);
    return (64'sd1 <<< (n - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int n);
    return -(64'sd1 <<< (n - 1));
  endfunction

  localparam logic signed [63:0] MAXV = sat_max(N);
  localparam logic signed [63:0] MINV = sat_min(N);

  typedef enum logic [1:0] {
    ACT_LIN  = 2'd0,
    ACT_RELU = 2'd1,
    ACT_CLIP = 2'd2,
    ACT_RSVD = 2'd3
  } act_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_WB   = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  function automatic logic signed [63:0] saturate(input logic signed [63:0] v,
                                                  input logic signed [63:0] lo,
                                                  input logic signed [63:0] hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/fx_sat_act.sv
// Combinational post-processing of a wide fixed-point accumulator:
// arithmetic shift right by FRAC (floor), saturation to the N-bit range,
// then activation (linear / ReLU / hard clip to [-1.0, +1.0]).
//   acc_i      : ACCW-bit signed accumulator (value scaled by 2^(2*FRAC))
//   act_mode_i : activation select (act_mode_e)
//   r_o        : N-bit signed result, Q(N-FRAC).FRAC
module fx_sat_act
  import seq_layer_pkg::*;
#(
  parameter int                 N      = seq_layer_pkg::N,
  parameter int                 FRAC   = seq_layer_pkg::FRAC,
  parameter int                 ACCW   = 2 * seq_layer_pkg::N + 3,
  parameter logic signed [63:0] SAT_HI = MAXV,
  parameter logic signed [63:0] SAT_LO = MINV
) (
  input  logic [ACCW-1:0] acc_i,
  input  logic [1:0]      act_mode_i,
  output logic [N-1:0]    r_o
);

  localparam logic signed [63:0] CLIP_HI = 64'sd1 <<< FRAC;
  localparam logic signed [63:0] CLIP_LO = -CLIP_HI;

  logic signed [ACCW-1:0] acc_sh;
  logic signed [63:0]     shifted;
  logic signed [63:0]     sat;
  logic signed [63:0]     res;

  // Arithmetic shift gives floor rounding for negative values.
  assign acc_sh  = $signed(acc_i) >>> FRAC;
  assign shifted = 64'(acc_sh);
  assign sat     = saturate(shifted, SAT_LO, SAT_HI);

  always_comb begin
    res = sat;
    case (act_mode_e'(act_mode_i))
      ACT_RELU: if (sat < 64'sd0) res = 64'sd0;
      ACT_CLIP: res = saturate(sat, CLIP_LO, CLIP_HI);
      default:  res = sat;
    endcase
  end

  assign r_o = N'(res);

endmodule

// File: rtl/seq_layer.sv
// Time-multiplexed fully-connected layer: SL nodes of SX inputs each are
// evaluated one node at a time on a single shared fixed-point MAC.
//   clk, rst     : rising-edge clock, asynchronous active-high reset
//   wload/waddr/wdata : weight-file write port, addr = j*(SX+1)+i, i=SX is bias
//   wr_err       : one-cycle pulse after a rejected write (busy or bad addr)
//   act_mode     : activation for the run, latched with start
//   start/busy/done : run handshake
//   x            : input vector, x[i] at [N*i +: N], latched with start
//   y            : output vector, y[j] at [N*j +: N], updated only with done
//   dbg_state_o  : current sequencer state (state_e)
//
// Handshake: start is honoured only while the sequencer is idle; the edge that
// samples it latches x and act_mode. busy is high from the next cycle through
// the last write-back cycle; done then pulses for exactly one cycle together
// with the atomic y update. start seen while not idle is dropped silently.
module seq_layer
  import seq_layer_pkg::*;
#(
  parameter int N    = seq_layer_pkg::N,
  parameter int FRAC = seq_layer_pkg::FRAC,
  parameter int SX   = 4,
  parameter int SL   = 4,
  parameter int AW   = $clog2(SL * (SX + 1))
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wload,
  input  logic [AW-1:0]     waddr,
  input  logic [N-1:0]      wdata,
  output logic              wr_err,
  input  logic [1:0]        act_mode,
  input  logic              start,
  input  logic [N*SX-1:0]   x,
  output logic              busy,
  output logic              done,
  output logic [N*SL-1:0]   y,
  output logic [1:0]        dbg_state_o
);

  localparam int NW   = SL * (SX + 1);
  localparam int IXW  = (NW > 1) ? $clog2(NW) : 1;
  localparam int IW   = (SX > 1) ? $clog2(SX) : 1;
  localparam int JW   = (SL > 1) ? $clog2(SL) : 1;
  localparam int ACCW = 2 * N + $clog2(SX + 1);

  localparam logic [IXW-1:0] STRIDE = IXW'(SX + 1);
  localparam logic [IXW-1:0] BOFF   = IXW'(SX);
  localparam logic [IW-1:0]  I_LAST = IW'(SX - 1);
  localparam logic [JW-1:0]  J_LAST = JW'(SL - 1);

  state_e                 state_q, state_d;
  logic [IW-1:0]          i_q, i_d;
  logic [JW-1:0]          j_q, j_d;
  logic signed [ACCW-1:0] acc_q, acc_d;
  logic [N-1:0]           x_q      [SX];
  logic [N-1:0]           x_d      [SX];
  logic [1:0]             mode_q, mode_d;
  logic [N-1:0]           shadow_q [SL];
  logic [N-1:0]           shadow_d [SL];
  logic [N-1:0]           y_q      [SL];
  logic [N-1:0]           y_d      [SL];
  logic                   done_q, done_d;
  logic                   wr_err_q, wr_err_d;
  logic [N-1:0]           w_q      [NW];

  logic                   addr_ok;
  logic                   w_en;
  logic [IXW-1:0]         w_idx;
  logic [IXW-1:0]         b_idx;
  logic signed [N-1:0]    w_sel;
  logic signed [N-1:0]    b_sel;
  logic signed [N-1:0]    x_sel;
  logic signed [2*N-1:0]  prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] bias_ext;
  logic [N-1:0]           node_r;

  // ---------------- weight file ----------------
  assign addr_ok  = 32'(waddr) < NW;
  assign w_en     = wload && addr_ok && (state_q == ST_IDLE);
  assign wr_err_d = wload && !w_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NW; k++) w_q[k] <= '0;
    end else if (w_en) begin
      w_q[IXW'(waddr)] <= wdata;
    end
  end

  // ---------------- MAC operand selection ----------------
  assign w_idx    = IXW'(j_q) * STRIDE + IXW'(i_q);
  assign b_idx    = IXW'(j_q) * STRIDE + BOFF;
  assign w_sel    = w_q[w_idx];
  assign b_sel    = w_q[b_idx];
  assign x_sel    = x_q[i_q];
  assign prod     = (2*N)'(w_sel) * (2*N)'(x_sel);
  assign prod_ext = ACCW'(prod);
  // Bias is aligned to the product scale (2*FRAC fractional bits).
  assign bias_ext = ACCW'(b_sel) <<< FRAC;

  fx_sat_act #(
    .N      (N),
    .FRAC   (FRAC),
    .ACCW   (ACCW),
    .SAT_HI (sat_max(N)),
    .SAT_LO (sat_min(N))
  ) u_sat_act (
    .acc_i      (acc_q),
    .act_mode_i (mode_q),
    .r_o        (node_r)
  );

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_MAC;
      ST_MAC:  if (i_q == I_LAST) state_d = ST_WB;
      ST_WB:   state_d = (j_q == J_LAST) ? ST_FIN : ST_MAC;
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy        = (state_q == ST_MAC) || (state_q == ST_WB);
    dbg_state_o = state_q;
  end

  // ---------------- datapath next values ----------------
  always_comb begin
    i_d      = i_q;
    j_d      = j_q;
    acc_d    = acc_q;
    x_d      = x_q;
    mode_d   = mode_q;
    shadow_d = shadow_q;
    y_d      = y_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          for (int k = 0; k < SX; k++) x_d[k] = x[k*N +: N];
          mode_d = act_mode;
          i_d    = '0;
          j_d    = '0;
        end
      end
      ST_MAC: begin
        // First term of a node restarts the accumulator with the bias folded in.
        if (i_q == '0) acc_d = prod_ext + bias_ext;
        else           acc_d = acc_q + prod_ext;
        i_d = (i_q == I_LAST) ? '0 : i_q + 1'b1;
      end
      ST_WB: begin
        shadow_d[j_q] = node_r;
        i_d           = '0;
        if (j_q != J_LAST) j_d = j_q + 1'b1;
      end
      ST_FIN: begin
        // Publish all nodes at once so y never shows a partial layer.
        y_d    = shadow_q;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q      <= '0;
      j_q      <= '0;
      acc_q    <= '0;
      mode_q   <= '0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      for (int k = 0; k < SX; k++) x_q[k] <= '0;
      for (int k = 0; k < SL; k++) begin
        shadow_q[k] <= '0;
        y_q[k]      <= '0;
      end
    end else begin
      i_q      <= i_d;
      j_q      <= j_d;
      acc_q    <= acc_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
      x_q      <= x_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
    end
  end

  assign done   = done_q;
  assign wr_err = wr_err_q;

  for (genvar g = 0; g < SL; g++) begin : g_y
    assign y[g*N +: N] = y_q[g];
  end

endmodule
